// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - func3 size codes, fault codes, FSM state encoding
//   - access_t: everything latched from the core for one memory access
//   - access_ok(): legality/alignment check for a size/direction/offset
package lsu_pkg;

    // func3 size/sign codes
    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    // fault codes reported with done
    localparam logic [1:0] F_NONE  = 2'd0;
    localparam logic [1:0] F_ALIGN = 2'd1;
    localparam logic [1:0] F_BUS   = 2'd2;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [29:0] waddr;
        logic [31:0] wd;
        logic [2:0]  size;
        logic [1:0]  off;
    } access_t;

    // Unsigned sizes only make sense for loads; 3/6/7 are not encodings.
    function automatic logic access_ok(input logic [2:0] size, input logic we,
                                       input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b1;
            SZ_H:    return ~off[0];
            SZ_W:    return off == 2'b00;
            SZ_BU:   return ~we;
            SZ_HU:   return ~we & ~off[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extraction: picks the byte/half addressed by offset out of the
// read word and sign- or zero-extends it according to func3.
//   word   in  32  word returned by the memory
//   offset in  2   byte offset within the word
//   size   in  3   func3 size/sign code
//   ext    out 32  extended load value (0 for illegal sizes)
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    output logic [31:0] ext
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    ext = {{24{b[7]}}, b};
            SZ_H:    ext = {{16{h[15]}}, h};
            SZ_W:    ext = word;
            SZ_BU:   ext = {24'd0, b};
            SZ_HU:   ext = {16'd0, h};
            default: ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit between the decoder and a single-port data memory.
// One access at a time: IDLE accepts a request, WAIT holds the memory
// request until mem_ready or timeout, DONE pulses done for one cycle.
//   clk, rst_n            clock, synchronous active-low reset
//   core_req/we/size      decoder memory controls (func3 size code)
//   core_addr, core_wd    ALU byte address, rs2 store data
//   core_rd, done, fault  extended load result and completion status
//   core_stall            hold PC while an access is in flight
//   mem_*                 request/ready memory interface
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_size,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wd,
    output logic [31:0] core_rd,
    output logic        core_stall,
    output logic        done,
    output logic [1:0]  fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    input  logic        mem_ready
);

    // Counter value in the last permitted WAIT cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    access_t          acc, acc_nxt;
    logic             legal;
    logic [31:0]      ld_ext;

    assign legal = access_ok(core_size, core_we, core_addr[1:0]);

    // Lane placement: stores replicate data across lanes and enable only
    // the addressed bytes; loads always read the whole word.
    always_comb begin
        acc_nxt.we    = core_we;
        acc_nxt.waddr = core_addr[31:2];
        acc_nxt.size  = core_size;
        acc_nxt.off   = core_addr[1:0];
        acc_nxt.be    = 4'b1111;
        acc_nxt.wd    = core_wd;
        if (core_we) begin
            case (core_size)
                SZ_B: begin
                    acc_nxt.be = 4'b0001 << core_addr[1:0];
                    acc_nxt.wd = {4{core_wd[7:0]}};
                end
                SZ_H: begin
                    acc_nxt.be = core_addr[1] ? 4'b1100 : 4'b0011;
                    acc_nxt.wd = {2{core_wd[15:0]}};
                end
                default: ;
            endcase
        end
    end

    lsu_load_ext u_ext (
        .word   (mem_rd),
        .offset (acc.off),
        .size   (acc.size),
        .ext    (ld_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            core_rd <= '0;
            fault   <= F_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req) begin
                        if (legal) begin
                            acc   <= acc_nxt;
                            cnt   <= '0;
                            state <= WAIT;
                        end else begin
                            core_rd <= '0;
                            fault   <= F_ALIGN;
                            state   <= DONE;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // ready in the timeout cycle still counts as completion
                    if (mem_ready) begin
                        core_rd <= acc.we ? 32'd0 : ld_ext;
                        fault   <= F_NONE;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        core_rd <= '0;
                        fault   <= F_BUS;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req    = (state == WAIT);
    assign mem_we     = acc.we;
    assign mem_be     = acc.be;
    assign mem_addr   = {acc.waddr, 2'b00};
    assign mem_wd     = acc.wd;
    assign done       = (state == DONE);
    assign core_stall = ((state == IDLE) && core_req) || (state == WAIT);

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit directly downstream of the main instruction decoder.
- Consumes the decoder's memory controls: the memory-request flag, write enable and 3-bit size/sign code (func3). Also takes the ALU-computed address and the rs2 write data.
- Drives a single-port data memory through a request/ready handshake.
- Returns the sign- or zero-extended load result, and a stall signal that the core ANDs into the PC enable.

Parameters:
- TIMEOUT, 255: max cycles in WAIT without mem_ready before a bus error is flagged; must be ≥1.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock, all flops rising-edge.
- rst_n  in  1  reset; synchronous and active-low.
- core_req  in  1  memory instruction present (decoder memi[4]).
- core_we  in  1  1 = store, 0 = load (decoder mwe).
- core_size  in  3  func3: 0 B, 1 H, 2 W, 4 BU, 5 HU; others illegal.
- core_addr  in  32  byte address from ALU.
- core_wd  in  32  store data (rs2).
- core_rd  out  32  extended load data; valid while done is high.
- core_stall  out  1  1 = hold PC and pipeline.
- done  out  1  one-cycle pulse: access completed or faulted.
- fault  out  2  0 none, 1 misaligned/illegal size, 2 bus timeout; valid with done.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word address, {core_addr[31:2], 2'b00}.
- mem_wd  out  32  lane-replicated store data.
- mem_rd  in  32  read word.
- mem_ready  in  1  access complete; read data valid in the same cycle.

Behaviour:
- States: IDLE, WAIT, DONE.
- Reset (rst_n=0 at an edge): state IDLE, counter 0. All mem_* outputs 0, core_rd 0, done 0, fault 0.
- Reset applied in WAIT aborts the access: mem_req is 0 after that edge, and a late mem_ready is ignored.
- Alignment check:
  - W requires addr[1:0]=0.
  - H/HU require addr[0]=0.
  - B/BU are always aligned.
  - Sizes 3, 6, 7 are illegal, as are sizes 4 or 5 with core_we=1.
- IDLE, core_req=0: core_stall=0, no action.
- IDLE, core_req=1, bad access:
  - Go to DONE with fault=1 and core_rd=0.
  - mem_req is never asserted.
  - core_stall=1 for this cycle.
- IDLE, core_req=1, legal access:
  - core_stall=1 combinationally in the same cycle.
  - Register mem_addr, mem_we, mem_be, mem_wd and the size/byte-offset; go to WAIT.
- WAIT:
  - mem_req=1 and all mem_* outputs held stable; core_stall=1.
  - Counter increments each cycle.
  - On mem_ready: capture the extended mem_rd into core_rd (0 for stores), fault=0, go to DONE.
  - If the counter reaches TIMEOUT with no mem_ready: mem_req drops, fault=2, core_rd=0, go to DONE.
  - mem_ready in the same cycle as the timeout wins (normal completion).
- DONE:
  - done=1, core_stall=0 (the instruction retires this cycle), mem_req=0.
  - Next state is IDLE unconditionally.
  - core_rd and fault hold until the next DONE.
- Minimum latency: request cycle → first WAIT cycle → DONE, so 3 cycles when mem_ready arrives in the first WAIT cycle.
- Store lanes:
  - B: mem_be = 4'b0001 << addr[1:0]; mem_wd = {4{wd[7:0]}}.
  - H: mem_be = addr[1] ? 4'b1100 : 4'b0011; mem_wd = {2{wd[15:0]}}.
  - W: mem_be = 4'b1111; mem_wd = wd.
- Loads: mem_be = 4'b1111. Select the byte/half by the offset, then sign-extend for B/H or zero-extend for BU/HU.
- mem_ready outside WAIT is ignored.

Decomposition:
- Package lsu_pkg holds:
  - size codes SZ_B=3'd0, SZ_H=3'd1, SZ_W=3'd2, SZ_BU=3'd4, SZ_HU=3'd5;
  - fault codes F_NONE, F_ALIGN, F_BUS;
  - the state encoding IDLE/WAIT/DONE.
- One combinational sub-module, lsu_load_ext: inputs word, offset, size; output extended 32-bit value. It is reused by the verification model.

Test Plan:
- Aligned load, size 0 (LB), addr 0x103, mem_rd 0x80FF_1234, mem_ready in the first WAIT cycle → mem_addr 0x100, core_rd 0xFFFF_FF80, done 3 cycles after request, core_stall high for 2 cycles.
- LHU, addr 0x102, mem_rd 0x8001_0000 → core_rd 0x0000_8001. LH with the same inputs → core_rd 0xFFFF_8001.
- SB, addr 0x201, wd 0x0000_00AB → mem_be 4'b0010, mem_wd 0xABAB_ABAB, mem_we=1. SW, addr 0x204 → mem_be 4'b1111.
- LW, addr 0x102 → no mem_req, done with fault=1, core_rd 0. SW with size=3 → fault=1.
- TIMEOUT=4, mem_ready never asserted → mem_req high for exactly 4 cycles, then done with fault=2. Repeat with mem_ready on the 4th cycle → fault=0.
- rst_n=0 during WAIT → mem_req 0 after the edge, state IDLE. A mem_ready pulse on the next cycle produces no done.
